// File: rtl/bnn_pkg.sv
// Shared constants and state encoding for the BNN front end (frame loader and packer).
// Optional checksum support is enabled with the FRAME_CHECKSUM_EN macro.
package bnn_pkg;

   localparam int IMG_BITS    = 900;
   localparam int FRAME_BYTES = 113;

   localparam logic [3:0] RESULT_BLANK = 4'd10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CHECK,
      ST_RUN,
      ST_HOLD,
      ST_CLEAR
   } loader_state_t;

endpackage

// File: rtl/img_byte_packer.sv
// Packs accepted host bytes LSB-first into the 900-bit image and tracks the byte count.
// With FRAME_CHECKSUM_EN a trailing XOR checksum byte is captured and compared.
module img_byte_packer import bnn_pkg::*; #(
   parameter int IMG_BITS    = bnn_pkg::IMG_BITS,
   parameter int FRAME_BYTES = bnn_pkg::FRAME_BYTES
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                byte_we_i,
   input  logic [7:0]          byte_i,
   input  logic                cnt_clear_i,
   output logic [IMG_BITS-1:0] img_o,
   output logic                frame_done_o
`ifdef FRAME_CHECKSUM_EN
   ,
   output logic                csum_ok_o
`endif
);

   localparam int         LAST_BITS = IMG_BITS - 8 * (FRAME_BYTES - 1);
   localparam logic [6:0] LAST_IDX  = 7'(FRAME_BYTES - 1);

   logic [IMG_BITS-1:0] img_q, img_d;
   logic [6:0]          cnt_q, cnt_d;
   logic [9:0]          bit_base;
`ifdef FRAME_CHECKSUM_EN
   logic                phase_q, phase_d;
   logic [7:0]          xor_q, xor_d;
   logic [7:0]          csum_q, csum_d;
`endif

   assign bit_base = {cnt_q, 3'b000};

   // The final image byte carries only the leftover bits; the counter returns to 0
   // as soon as the frame (or its checksum byte) has been taken.
   always_comb begin
      img_d        = img_q;
      cnt_d        = cnt_q;
      frame_done_o = 1'b0;
`ifdef FRAME_CHECKSUM_EN
      phase_d      = phase_q;
      xor_d        = xor_q;
      csum_d       = csum_q;
`endif
      if (cnt_clear_i) begin
         cnt_d = '0;
`ifdef FRAME_CHECKSUM_EN
         phase_d = 1'b0;
`endif
      end else if (byte_we_i) begin
`ifdef FRAME_CHECKSUM_EN
         if (phase_q) begin
            csum_d       = byte_i;
            phase_d      = 1'b0;
            frame_done_o = 1'b1;
         end else begin
            xor_d = (cnt_q == '0) ? byte_i : (xor_q ^ byte_i);
`endif
            if (cnt_q == LAST_IDX) begin
               img_d[IMG_BITS-1 -: LAST_BITS] = byte_i[LAST_BITS-1:0];
               cnt_d = '0;
`ifdef FRAME_CHECKSUM_EN
               phase_d = 1'b1;
`else
               frame_done_o = 1'b1;
`endif
            end else begin
               img_d[bit_base +: 8] = byte_i;
               cnt_d = cnt_q + 7'd1;
            end
`ifdef FRAME_CHECKSUM_EN
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         img_q   <= '0;
         cnt_q   <= '0;
`ifdef FRAME_CHECKSUM_EN
         phase_q <= 1'b0;
         xor_q   <= '0;
         csum_q  <= '0;
`endif
      end else begin
         img_q   <= img_d;
         cnt_q   <= cnt_d;
`ifdef FRAME_CHECKSUM_EN
         phase_q <= phase_d;
         xor_q   <= xor_d;
         csum_q  <= csum_d;
`endif
      end
   end

   assign img_o = img_q;
`ifdef FRAME_CHECKSUM_EN
   assign csum_ok_o = (xor_q == csum_q);
`endif

endmodule

// File: rtl/img_frame_loader.sv
// Host-side frame loader: collects a frame, drives the bnn_interface handshake and
// holds the class result until the host acknowledges it. FRAME_CHECKSUM_EN adds CHECK/frame_err.
module img_frame_loader import bnn_pkg::*; #(
   parameter int IMG_BITS    = bnn_pkg::IMG_BITS,
   parameter int FRAME_BYTES = bnn_pkg::FRAME_BYTES
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          rx_data,
   input  logic                rx_valid,
   output logic                rx_ready,
   input  logic                frame_abort,
   output logic [IMG_BITS-1:0] img_out,
   output logic                bnn_enable,
   output logic                bnn_clear,
   input  logic [3:0]          bnn_result,
   input  logic                bnn_result_ready,
   output logic [3:0]          result_out,
   output logic                result_valid,
   input  logic                result_ack
`ifdef FRAME_CHECKSUM_EN
   ,
   output logic                frame_err
`endif
);

   loader_state_t state_q, state_d;
   logic [3:0]    result_q, result_d;
   logic          byte_we;
   logic          cnt_clear;
   logic          frame_done;
`ifdef FRAME_CHECKSUM_EN
   logic          csum_ok;
`endif

   // An abort in the same cycle as a valid byte wins, so that byte is never written.
   assign rx_ready = !rst && ((state_q == ST_IDLE) || (state_q == ST_LOAD));
   assign byte_we  = rx_valid && rx_ready && !frame_abort;

   img_byte_packer #(
      .IMG_BITS    (IMG_BITS),
      .FRAME_BYTES (FRAME_BYTES)
   ) u_packer (
      .clk          (clk),
      .rst          (rst),
      .byte_we_i    (byte_we),
      .byte_i       (rx_data),
      .cnt_clear_i  (cnt_clear),
      .img_o        (img_out),
      .frame_done_o (frame_done)
`ifdef FRAME_CHECKSUM_EN
      ,
      .csum_ok_o    (csum_ok)
`endif
   );

   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      cnt_clear = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (byte_we) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            if (frame_abort) begin
               cnt_clear = 1'b1;
               state_d   = ST_IDLE;
            end else if (frame_done) begin
`ifdef FRAME_CHECKSUM_EN
               state_d = ST_CHECK;
`else
               state_d = ST_RUN;
`endif
            end
         end
         ST_CHECK: begin
`ifdef FRAME_CHECKSUM_EN
            if (frame_abort) begin
               cnt_clear = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               state_d = csum_ok ? ST_RUN : ST_IDLE;
            end
`else
            state_d = ST_IDLE;
`endif
         end
         ST_RUN: begin
            if (frame_abort) begin
               state_d = ST_CLEAR;
            end else if (bnn_result_ready) begin
               result_d = bnn_result;
               state_d  = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (frame_abort || result_ack) state_d = ST_CLEAR;
         end
         ST_CLEAR: begin
            cnt_clear = 1'b1;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
      end
   end

   assign bnn_enable   = (state_q == ST_RUN);
   assign bnn_clear    = (state_q == ST_CLEAR);
   assign result_valid = (state_q == ST_HOLD);
   assign result_out   = result_q;
`ifdef FRAME_CHECKSUM_EN
   assign frame_err    = (state_q == ST_CHECK) && !frame_abort && !csum_ok;
`endif

endmodule

// File: doc/img_frame_loader.md
# img_frame_loader

Upstream stage of `bnn_interface`. Accepts a byte stream from the host link, packs it into the 900-bit 30×30 binary image, and hands the image to `bnn_interface` with a full enable/ready/clear handshake. Latches the 4-bit class result and presents it to the host until acknowledged.

## Interface

Parameters:
- `IMG_BITS`, 900: image width in bits (30×30).
- `FRAME_BYTES`, 113: bytes per frame, equal to ceil(IMG_BITS/8).

Ports:
- `clk`  in  1: system clock, shared with `bnn_interface`.
- `rst`  in  1: reset, synchronous, active-high.
- `rx_data`  in  8: image byte from the host link.
- `rx_valid`  in  1: `rx_data` valid.
- `rx_ready`  out  1: byte accepted when `rx_valid && rx_ready`.
- `frame_abort`  in  1: discard the partial frame and return to IDLE.
- `img_out`  out  900: packed image, to `bnn_interface.img_in`.
- `bnn_enable`  out  1: start request, to `bnn_interface`.
- `bnn_clear`  out  1: one-cycle clear, to `bnn_interface`.
- `bnn_result`  in  4: from `bnn_interface.result_out`.
- `bnn_result_ready`  in  1: from `bnn_interface.result_ready`.
- `result_out`  out  4: latched class, 0–9; 10 means blank image.
- `result_valid`  out  1: `result_out` is valid.
- `result_ack`  in  1: host has consumed the result.

## Operation

States: IDLE, LOAD, CHECK (only with the checksum macro), RUN, HOLD, CLEAR.

**IDLE**
- `rx_ready`=1.
- The first accepted byte is written and `byte_cnt`=1, then the block goes to LOAD.

**LOAD**
- `rx_ready`=1.
- Byte k is written to `img_out[8k+j]` for bit j (LSB-first).
- Byte 112 writes only bits 3:0; bits 7:4 are ignored.
- On the accepted byte with `byte_cnt`==FRAME_BYTES-1, the block goes to RUN (or CHECK with the macro).

**RUN**
- `rx_ready`=0.
- `bnn_enable` is held at 1 until `bnn_result_ready`=1 is sampled.
- On that sample: latch `bnn_result` into `result_out`, set `result_valid`=1, drop `bnn_enable`, go to HOLD.

**HOLD**
- `result_valid` is held at 1.
- On `result_ack`, go to CLEAR.

**CLEAR**
- `bnn_clear`=1 for exactly one cycle, `result_valid`=0, `byte_cnt`=0, then go to IDLE.
- `img_out` is not cleared; it is overwritten by the next frame.

**Abort and priority**
- `frame_abort` in LOAD or CHECK: go to IDLE and set `byte_cnt`=0.
- `frame_abort` in RUN or HOLD: go to CLEAR, so `bnn_interface` is cleared. `result_valid` drops in CLEAR.
- `frame_abort` is ignored in IDLE and CLEAR.
- Priority: `rst` > `frame_abort` > byte accept.
- If a byte and `frame_abort` arrive in the same cycle, the byte is dropped.

**Arithmetic and inputs**
- `byte_cnt` is 7 bits and never exceeds FRAME_BYTES-1. There is no wrap-around; it is reset on frame completion or abort.
- Bytes arriving while `rx_ready`=0 are not consumed; the host holds them.
- `result_ack` outside HOLD is ignored.
- `bnn_result_ready` outside RUN is ignored.

## Timing

**Reset values:** `rx_ready`=0 during reset, 1 in the first IDLE cycle; `img_out`=0, `bnn_enable`=0, `bnn_clear`=0, `result_out`=0, `result_valid`=0; state IDLE.

**Latencies**
- Last byte accepted at cycle N: `bnn_enable`=1 from cycle N+1 (N+2 with the macro, CHECK taking one cycle).
- `bnn_result_ready` sampled at cycle M: `result_out` and `result_valid` are valid at M+1, and `bnn_enable`=0 at M+1.
- `result_ack` at cycle A: `bnn_clear`=1 at A+1 only, IDLE and `rx_ready`=1 at A+2.

**Throughput:** at most one byte per cycle.

## Configuration

`FRAME_CHECKSUM_EN`:
- **Defined:**
  - Each frame carries one extra byte after the image bytes, the XOR of all FRAME_BYTES image bytes.
  - CHECK compares it against a running XOR accumulator.
  - Match: go to RUN.
  - Mismatch: go to IDLE without asserting `bnn_enable`, and pulse the extra output `frame_err` (1 bit) for one cycle.
- **Undefined:** no checksum byte, no CHECK state, no `frame_err` port.

## Structure

**Package `bnn_pkg`:**
- `IMG_BITS`, `FRAME_BYTES`.
- `RESULT_BLANK`=4'd10.
- Loader state enum `loader_state_t`.

**Sub-module `img_byte_packer`:**
- Owns `byte_cnt`, the 900-bit shift/write logic and, under the macro, the XOR accumulator.
- Exposes `frame_done` and `cnt_clear`.
- The FSM stays in `img_frame_loader`.

## Test plan

- **Reset and frame load:** after reset, stream 113 bytes with bytes 0..111=8'hA5 and byte 112=8'hF3, with the `bnn_interface` model returning result 7 → `img_out[895:0]` repeats A5 LSB-first and `img_out[899:896]`=4'h3; `bnn_enable` asserts the cycle after the last byte; `result_out`=7 and `result_valid`=1 one cycle after `bnn_result_ready`.
- **Result acknowledge:** `result_ack` in HOLD → `bnn_clear` is high exactly one cycle, `result_valid`=0, and `rx_ready`=1 two cycles after the ack.
- **Backpressure:** `rx_valid` held high during RUN and HOLD → no byte is consumed and the next frame starts cleanly after CLEAR.
- **Abort during load:** `frame_abort` after 50 bytes, with a byte valid in the same cycle → `byte_cnt`=0 and IDLE; a following full frame loads correctly with no `bnn_enable` before byte 113.
- **Abort during inference:** `frame_abort` in RUN → `bnn_clear` pulses, `result_valid` stays 0, return to IDLE.
- **Checksum (`FRAME_CHECKSUM_EN`):** a wrong checksum byte → `frame_err` pulses and `bnn_enable` never asserts; a correct checksum → normal run.
